// File: rtl/ps2_key_serializer.sv
// PS/2 device serializer: key event -> set-2 bytes (E0/F0 prefixes) -> byte FIFO -> framed serial output.
// Events drop whole when the FIFO lacks room; a host-request receive path exists only with PS2SER_HOST_CMD_EN.
module ps2_key_serializer #(
    parameter int DEPTH       = 16,
    parameter int HALF_PERIOD = 1145,
    parameter int IDLE_GAP    = 1432
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_out,
    output logic        ps2_data_out,
    output logic        busy,
    output logic        overflow,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int MAXC = (IDLE_GAP > HALF_PERIOD) ? IDLE_GAP : HALF_PERIOD;
    localparam int CW   = ($clog2(MAXC + 1) > 11) ? $clog2(MAXC + 1) : 11;

    typedef enum logic [2:0] {
        IDLE, HOLDOFF, TX_HI, TX_LO
`ifdef PS2SER_HOST_CMD_EN
        , RX_HI, RX_LO
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bit_q, bit_d;
    logic           tog_q, evt_vld_q, overflow_q;
    logic [9:0]     evt_q;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [LW-1:0]  lvl_q, lvl_d, free;
    logic           ext, rel, push_ok, tx_done, pop_fifo, phase_end, rep_vld;
    logic [1:0]     need;
    logic [7:0]     code, tx_byte, rep_head;
    logic [7:0]     pb [3];
    logic [10:0]    frame;

    assign ext     = evt_q[8];
    assign rel     = ~evt_q[9];
    assign code    = evt_q[7:0];
    assign need    = 2'd1 + {1'b0, ext} + {1'b0, rel};
    // free space is judged on the level before any same-cycle pop
    assign free    = LW'(DEPTH) - lvl_q;
    assign push_ok = evt_vld_q && (free >= LW'(need));
    assign pb[0]   = ext ? 8'hE0 : (rel ? 8'hF0 : code);
    assign pb[1]   = (ext && rel) ? 8'hF0 : code;
    assign pb[2]   = code;
    assign lvl_d   = lvl_q + (push_ok ? LW'(need) : LW'(0)) - LW'(pop_fifo);

    always_ff @(posedge clk) begin
        if (reset) begin
            tog_q      <= ps2_key[10];
            evt_vld_q  <= 1'b0;
            evt_q      <= '0;
            overflow_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            lvl_q      <= '0;
        end else begin
            tog_q      <= ps2_key[10];
            evt_vld_q  <= ps2_key[10] ^ tog_q;
            evt_q      <= ps2_key[9:0];
            overflow_q <= evt_vld_q && !push_ok;
            if (push_ok)
                wr_q <= wr_q + AW'(need);
            if (pop_fifo)
                rd_q <= rd_q + AW'(1);
            lvl_q      <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            for (int k = 0; k < 3; k++)
                if (k < int'(need))
                    mem[wr_q + AW'(k)] <= pb[k];
    end

    assign tx_byte   = rep_vld ? rep_head : mem[rd_q];
    assign frame     = {1'b1, ~^tx_byte, tx_byte, 1'b0};
    assign phase_end = (cnt_q == CW'(HALF_PERIOD - 1));
    assign pop_fifo  = tx_done && !rep_vld;

`ifdef PS2SER_HOST_CMD_EN
    logic [7:0]    rep_q [2];
    logic [1:0]    rep_n_q;
    logic [8:0]    rx_sr_q;
    logic [7:0]    cmd_byte_q;
    logic          cmd_valid_q, rx_done, rts_cond, rts_hit;
    logic [CW-1:0] rts_q;

    assign rep_vld   = (rep_n_q != 2'd0);
    assign rep_head  = rep_q[0];
    assign rts_cond  = (state_q == IDLE || state_q == HOLDOFF) && ps2_clk_in && !ps2_data_in;
    assign rts_hit   = rts_cond && (rts_q == CW'(HALF_PERIOD - 1));
    assign cmd_valid = cmd_valid_q;
    assign cmd_byte  = cmd_byte_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_q[0]    <= 8'h00;
            rep_q[1]    <= 8'h00;
            rep_n_q     <= 2'd0;
            rx_sr_q     <= '0;
            cmd_byte_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
            rts_q       <= '0;
        end else begin
            rts_q       <= rts_cond ? rts_q + CW'(1) : '0;
            cmd_valid_q <= rx_done;
            if (state_q == RX_HI && phase_end && bit_q < 4'd9)
                rx_sr_q <= {ps2_data_in, rx_sr_q[8:1]};
            if (rx_done) begin
                cmd_byte_q <= rx_sr_q[7:0];
                rep_n_q    <= 2'd1;
                if (!(^rx_sr_q)) begin
                    rep_q[0] <= 8'hFE;
                end else if (rx_sr_q[7:0] == 8'hEE) begin
                    rep_q[0] <= 8'hEE;
                end else if (rx_sr_q[7:0] == 8'hFF) begin
                    rep_q[0] <= 8'hFA;
                    rep_q[1] <= 8'hAA;
                    rep_n_q  <= 2'd2;
                end else begin
                    rep_q[0] <= 8'hFA;
                end
            end else if (tx_done && rep_vld) begin
                rep_q[0] <= rep_q[1];
                rep_n_q  <= rep_n_q - 2'd1;
            end
        end
    end
`else
    assign rep_vld   = 1'b0;
    assign rep_head  = 8'h00;
    assign cmd_valid = 1'b0;
    assign cmd_byte  = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        tx_done = 1'b0;
`ifdef PS2SER_HOST_CMD_EN
        rx_done = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (lvl_q != '0 || rep_vld)
                    state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (!(ps2_clk_in && ps2_data_in)) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(IDLE_GAP - 1)) begin
                    state_d = TX_HI;
                    cnt_d   = '0;
                end
            end
            TX_HI: begin
                if (phase_end) begin
                    cnt_d = '0;
                    // host holding the clock low means inhibit: abandon and resend the whole byte
                    if (!ps2_clk_in) begin
                        state_d = HOLDOFF;
                        bit_d   = '0;
                    end else begin
                        state_d = TX_LO;
                    end
                end
            end
            TX_LO: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (bit_q == 4'd10) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        tx_done = 1'b1;
                    end else begin
                        state_d = TX_HI;
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
`ifdef PS2SER_HOST_CMD_EN
            RX_HI: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = RX_LO;
                end
            end
            RX_LO: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (bit_q == 4'd10) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        rx_done = 1'b1;
                    end else begin
                        state_d = RX_HI;
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef PS2SER_HOST_CMD_EN
        if (rts_hit) begin
            state_d = RX_HI;
            cnt_d   = '0;
            bit_d   = '0;
        end
`endif
    end

    always_comb begin
        ps2_clk_out  = 1'b1;
        ps2_data_out = 1'b1;
        case (state_q)
            TX_HI: ps2_data_out = frame[bit_q];
            TX_LO: begin
                ps2_clk_out  = 1'b0;
                ps2_data_out = frame[bit_q];
            end
`ifdef PS2SER_HOST_CMD_EN
            RX_HI: ps2_data_out = (bit_q != 4'd10);
            RX_LO: begin
                ps2_clk_out  = 1'b0;
                ps2_data_out = (bit_q != 4'd10);
            end
`endif
            default: ;
        endcase
    end

    assign busy     = (lvl_q != '0) || (state_q != IDLE) || rep_vld;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Directed bench: decodes device frames off the lines and scores them against a byte-queue model of key events.
`timescale 1ns/1ps
module tb_ps2_key_serializer;
    localparam int DEPTH = 4;
    localparam int HP    = 4;
    localparam int GAP   = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = 11'h400;
    logic        host_clk_low = 1'b0;
    logic        ps2_clk_in, ps2_data_in;
    logic        ps2_clk_out, ps2_data_out, busy, overflow, cmd_valid;
    logic [7:0]  cmd_byte;

    assign ps2_clk_in  = ps2_clk_out & ~host_clk_low;
    assign ps2_data_in = ps2_data_out;

    ps2_key_serializer #(.DEPTH(DEPTH), .HALF_PERIOD(HP), .IDLE_GAP(GAP)) dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out),
        .busy(busy), .overflow(overflow), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0]  exp_q [$];
    int          ovf_due [$];
    logic [10:0] frames [$];
    int          nfall = 0, nbits = 0, last_fall = -1, first_fall = 0, ovf_seen = 0;
    logic [10:0] cur = '0;
    logic        prev_clk = 1'b1;
    logic        exp_ovf, fmt_ok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: per-cycle output rules plus line-level frame decoding.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            nbits    = 0;
            prev_clk = 1'b1;
        end else begin
            exp_ovf = 1'b0;
            foreach (ovf_due[i]) if (ovf_due[i] == cyc) exp_ovf = 1'b1;
            chk("overflow", overflow, exp_ovf);
            if (overflow) ovf_seen++;
            chk("cmd_valid", cmd_valid, 0);
            chk("cmd_byte", cmd_byte, 0);
            if (!ps2_clk_out || !ps2_data_out) chk("busy_in_frame", busy, 1);
            if (prev_clk && !ps2_clk_out) begin
                nfall++;
                if (nbits != 0 && (cyc - last_fall) != 2 * HP) nbits = 0;
                if (nbits == 0) begin
                    first_fall = cyc;
                    if (last_fall >= 0) chk("frame_gap", (cyc - last_fall) >= GAP + 2 * HP, 1);
                end
                cur[nbits] = ps2_data_out;
                nbits++;
                last_fall = cyc;
                if (nbits == 11) begin
                    fmt_ok = (cur[0] == 1'b0) && (cur[10] == 1'b1) && ($countones(cur[9:1]) % 2 == 1);
                    chk("frame_format", fmt_ok, 1);
                    chk("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("frame_byte", cur[8:1], exp_q.pop_front());
                    frames.push_back(cur);
                    nbits = 0;
                end
            end
            prev_clk = ps2_clk_out;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic ext, input logic press, input logic [7:0] code);
        logic [7:0] b [$];
        if (ext)    b.push_back(8'hE0);
        if (!press) b.push_back(8'hF0);
        b.push_back(code);
        if (DEPTH - exp_q.size() >= b.size()) foreach (b[i]) exp_q.push_back(b[i]);
        else ovf_due.push_back(cyc + 3);
        ps2_key = {~ps2_key[10], press, ext, code};
        tick(1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin tick(1); t++; end
        chk(name, exp_q.size(), 0);
        tick(5);
    endtask

    task automatic wait_fall(input int target);
        int t = 0;
        while (nfall < target && t < 1000) begin tick(1); t++; end
        chk("wait_fall", nfall >= target, 1);
    endtask

    initial begin
        int n0, o0, rel_cyc, t;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_clk_out", ps2_clk_out, 1);
        chk("rst_data_out", ps2_data_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        tick(20);
        chk("no_spurious_edges", nfall, 0);
        chk("no_spurious_busy", busy, 0);

        // Press A
        n0 = nfall;
        send(1'b0, 1'b1, 8'h1C);
        drain("t1_drain");
        chk("t1_edges", nfall - n0, 11);
        chk("t1_bits", frames[frames.size() - 1], 11'b10000111000);

        // Release right arrow: E0, F0, 74
        n0 = nfall;
        send(1'b1, 1'b0, 8'h74);
        drain("t2_drain");
        chk("t2_edges", nfall - n0, 33);
        chk("t2_e0", frames[frames.size() - 3], {1'b1, 1'b0, 8'hE0, 1'b0});
        chk("t2_f0", frames[frames.size() - 2], {1'b1, 1'b1, 8'hF0, 1'b0});
        chk("t2_74", frames[frames.size() - 1], {1'b1, 1'b1, 8'h74, 1'b0});

        // Host inhibits during bit 4
        n0 = nfall;
        send(1'b0, 1'b1, 8'h1C);
        wait_fall(n0 + 4);
        t = 0;
        while (ps2_clk_out !== 1'b1 && t < 100) begin tick(1); t++; end
        host_clk_low = 1'b1;
        tick(20);
        chk("t3_no_edges_inhibit", nfall - n0, 4);
        chk("t3_busy_inhibit", busy, 1);
        chk("t3_clk_released", ps2_clk_out, 1);
        rel_cyc = cyc;
        host_clk_low = 1'b0;
        drain("t3_drain");
        chk("t3_edges", nfall - n0, 15);
        chk("t3_resend_gap", (first_fall - rel_cyc) >= GAP + HP, 1);
        chk("t3_bits", frames[frames.size() - 1], 11'b10000111000);

        // Two extended releases back to back into a 4-deep FIFO
        n0 = nfall;
        o0 = ovf_seen;
        send(1'b1, 1'b0, 8'h74);
        send(1'b1, 1'b0, 8'h75);
        drain("t4_drain");
        chk("t4_edges", nfall - n0, 33);
        chk("t4_ovf_pulses", ovf_seen - o0, 1);

        // Reset during bit 6 with the FIFO full
        n0 = nfall;
        send(1'b1, 1'b0, 8'h74);
        send(1'b0, 1'b1, 8'h1C);
        wait_fall(n0 + 7);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_clk_out", ps2_clk_out, 1);
        chk("t5_data_out", ps2_data_out, 1);
        chk("t5_busy", busy, 0);
        #1;
        exp_q.delete();
        reset = 1'b0;
        tick(200);
        chk("t5_no_edges", nfall - n0, 7);
        chk("t5_busy_after", busy, 0);

        // Queue fully cleared: a fresh press produces exactly one frame
        n0 = nfall;
        send(1'b0, 1'b1, 8'h1C);
        drain("t6_drain");
        chk("t6_edges", nfall - n0, 11);
        chk("t6_bits", frames[frames.size() - 1], 11'b10000111000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
